// File: rtl/multi_cycle_cla_subtractor.sv
// rtl/multi_cycle_cla_subtractor.sv - sequential subtractor, one look-ahead slice per cycle
module multi_cycle_cla_subtractor #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] inp_A,
  input  logic [WIDTH-1:0] inp_B,
  input  logic             inp_bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_D,
  output logic             out_bout,
  output logic             out_ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   last_slice;

  // Operands shift right each cycle so the active slice always sits at the LSBs;
  // completed difference slices shift in from the top of res_q.
  logic [WIDTH-1:0]       a_q, b_q;
  logic [WIDTH-SLICE-1:0] res_q;
  logic                   carry_q;
  logic [CNT_W-1:0]       cnt_q;

  logic [SLICE-1:0] g, p, sum;
  logic [SLICE:0]   carries;

  // Full look-ahead: every carry is a flat sum of generate terms and the slice carry-in.
  function automatic logic [SLICE:0] cla_carries(input logic [SLICE-1:0] gen,
                                                 input logic [SLICE-1:0] prop,
                                                 input logic             cin);
    logic [SLICE:0] c;
    logic           pp;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      c[i+1] = gen[i];
      pp     = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & gen[j]);
        pp     = pp & prop[j];
      end
      c[i+1] = c[i+1] | (pp & cin);
    end
    return c;
  endfunction

  assign g       = a_q[SLICE-1:0] & ~b_q[SLICE-1:0];
  assign p       = a_q[SLICE-1:0] ^ ~b_q[SLICE-1:0];
  assign carries = cla_carries(g, p, carry_q);
  assign sum     = p ^ carries[SLICE-1:0];

  assign last_slice = (state == S_RUN) && (cnt_q == LAST);
  assign busy       = (state == S_RUN);
  assign done       = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        accept    = start;
        state_nxt = start ? S_RUN : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      out_D    <= '0;
      out_bout <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (accept) begin
      a_q     <= inp_A;
      b_q     <= inp_B;
      res_q   <= '0;
      carry_q <= ~inp_bin;
      cnt_q   <= '0;
    end else if (state == S_RUN) begin
      a_q     <= a_q >> SLICE;
      b_q     <= b_q >> SLICE;
      res_q   <= {sum, res_q[WIDTH-SLICE-1:SLICE]};
      carry_q <= carries[SLICE];
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_slice) begin
        // On the last slice the operand LSBs hold the original sign bits.
        out_D    <= {sum, res_q};
        out_bout <= ~carries[SLICE];
        out_ovf  <= (a_q[SLICE-1] ^ b_q[SLICE-1]) & (sum[SLICE-1] ^ a_q[SLICE-1]);
      end
    end
  end

endmodule

// File: tb/tb_multi_cycle_cla_subtractor.sv
// tb/tb_multi_cycle_cla_subtractor.sv - directed self-checking bench for multi_cycle_cla_subtractor
module tb_multi_cycle_cla_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] inp_A = '0;
  logic [31:0] inp_B = '0;
  logic        inp_bin = 1'b0;
  logic        busy, done, out_bout, out_ovf;
  logic [31:0] out_D;

  int total = 0;
  int bad   = 0;

  multi_cycle_cla_subtractor #(.WIDTH(32), .SLICE(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .inp_A    (inp_A),
    .inp_B    (inp_B),
    .inp_bin  (inp_bin),
    .busy     (busy),
    .done     (done),
    .out_D    (out_D),
    .out_bout (out_bout),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a request for one cycle; returns at the falling edge right after the accept edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic bin);
    @(negedge clk);
    inp_A   = a;
    inp_B   = b;
    inp_bin = bin;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    inp_A   = 32'hDEAD_BEEF;
    inp_B   = 32'h0BAD_F00D;
    inp_bin = 1'b1;
  endtask

  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (!done && cyc < 30) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic bin, input logic [31:0] exp_d,
                           input logic exp_bout, input logic exp_ovf);
    int cyc, bcnt;
    start_op(a, b, bin);
    wait_done(cyc, bcnt);
    check({tag, "_latency"}, cyc, 8);
    check({tag, "_busy_cycles"}, bcnt, 8);
    check({tag, "_D"}, out_D, exp_d);
    check({tag, "_bout"}, {31'b0, out_bout}, {31'b0, exp_bout});
    check({tag, "_ovf"}, {31'b0, out_ovf}, {31'b0, exp_ovf});
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int cyc, bcnt, ndone;
    logic [32:0] ref_full;
    logic [31:0] ra, rb;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_D", out_D, 32'd0);
    check("rst_bout", {31'b0, out_bout}, 32'd0);
    check("rst_ovf", {31'b0, out_ovf}, 32'd0);
    rst_n = 1'b1;

    // Directed arithmetic and boundaries
    run_check("sub_7_3",   32'd7,          32'd3,          1'b0, 32'h0000_0004, 1'b0, 1'b0);
    run_check("sub_3_7",   32'd3,          32'd7,          1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0);
    run_check("sub_0_0_b", 32'd0,          32'd0,          1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_check("ovf_neg",   32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_check("ovf_pos",   32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000, 1'b1, 1'b1);

    // Start pulsed mid-RUN is ignored; previous result held during RUN
    start_op(32'd10, 32'd4, 1'b0);
    repeat (2) @(negedge clk);
    check("hold_D_in_run", out_D, 32'h8000_0000);
    start = 1'b1;
    inp_A = 32'd1;
    inp_B = 32'd1;
    inp_bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bcnt);
    check("ign_latency", cyc, 5);
    check("ign_D", out_D, 32'd6);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ign_no_second_done", ndone, 0);
    check("ign_idle_busy", {31'b0, busy}, 32'd0);

    // Start held through DONE: back-to-back with no IDLE bubble
    start_op(32'd20, 32'd3, 1'b0);
    @(negedge clk);
    start = 1'b1;
    inp_A = 32'd3;
    inp_B = 32'd7;
    inp_bin = 1'b0;
    wait_done(cyc, bcnt);
    check("b2b_first_D", out_D, 32'd17);
    @(negedge clk);
    start = 1'b0;
    inp_A = 32'h1234_5678;
    check("b2b_busy_no_bubble", {31'b0, busy}, 32'd1);
    check("b2b_done_low", {31'b0, done}, 32'd0);
    wait_done(cyc, bcnt);
    check("b2b_latency", cyc, 8);
    check("b2b_D", out_D, 32'hFFFF_FFFC);
    check("b2b_bout", {31'b0, out_bout}, 32'd1);

    // Reset mid-RUN aborts and clears outputs
    start_op(32'h1234_5678, 32'd1, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_D", out_D, 32'd0);
    check("abort_bout", {31'b0, out_bout}, 32'd0);
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    rst_n = 1'b1;
    run_check("after_rst", 32'd9, 32'd2, 1'b0, 32'd7, 1'b0, 1'b0);

    // Small-operand sweep against a reference model
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        ra = i;
        rb = j;
        ref_full = {1'b0, ra} - {1'b0, rb};
        run_check($sformatf("sweep_%0d_%0d", i, j), ra, rb, 1'b0, ref_full[31:0], ref_full[32],
                  (ra[31] ^ rb[31]) & (ref_full[31] ^ ra[31]));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
